// File: rtl/fifo_ser_pkg.sv
// Shared types and default constants for the FIFO word serializer.
//   ser_state_e : serializer FSM states (IDLE, SHIFT, GAP)
//   DEF_DATA_W  : default FIFO word width / serial frame length
//   DEF_CNT_W   : default width of the sent-word counter
package fifo_ser_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data (has priority over shift)
//   load_data  : parallel word
//   shift      : advance by one bit toward the serial output
//   ser_bit    : current serial bit (MSB or LSB of the register per MSB_FIRST)
module piso_shift_reg #(
    parameter int unsigned W         = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    output logic         ser_bit
);

    logic [W-1:0] shreg_q;

    // Register: load wins over shift; vacated positions fill with zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= load_data;
        end else if (shift) begin
            if (MSB_FIRST) begin
                shreg_q <= {shreg_q[W-2:0], 1'b0};
            end else begin
                shreg_q <= {1'b0, shreg_q[W-1:1]};
            end
        end
    end

    assign ser_bit = MSB_FIRST ? shreg_q[W-1] : shreg_q[0];

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops 16-bit words from a first-word-fall-through FIFO and streams them
// out bit-serially on a valid/ready link with start/end-of-word markers,
// followed by an optional idle gap.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : permits new pops (a word in progress always finishes)
//   fifo_empty     : FIFO empty flag
//   fifo_data      : FIFO head word, valid while !fifo_empty
//   fifo_wr_active : FIFO writer commits this cycle (reads would be dropped)
//   fifo_rd_en     : pop request, only ever asserted in IDLE
//   tx_valid       : tx_bit valid
//   tx_ready       : downstream accepts tx_bit
//   tx_bit         : serial data bit
//   tx_sof/tx_eof  : first / last bit of the word
//   busy           : FSM not in IDLE
//   word_count     : words fully sent, wraps modulo 2^CNT_W
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_wr_active,
    output logic              fifo_rd_en,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_bit,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count
);

    localparam int unsigned BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned LAST_BIT = DATA_W - 1;

    ser_state_e        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;

    logic load_c;
    logic shift_c;
    logic pop_c;
    logic ser_bit;
    logic first_bit_c;
    logic last_bit_c;

    assign first_bit_c = (bit_cnt_q == '0);
    assign last_bit_c  = (bit_cnt_q == BIT_W'(LAST_BIT));

    piso_shift_reg #(
        .W         (DATA_W),
        .MSB_FIRST (MSB_FIRST != 0)
    ) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .load_data (fifo_data),
        .shift     (shift_c),
        .ser_bit   (ser_bit)
    );

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            word_count_q <= word_count_d;
        end
    end

    // Next-state, counters and link outputs.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        word_count_d = word_count_q;
        load_c       = 1'b0;
        shift_c      = 1'b0;
        pop_c        = 1'b0;
        tx_valid     = 1'b0;
        tx_bit       = 1'b0;
        tx_sof       = 1'b0;
        tx_eof       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Never pop while the writer owns the FIFO this cycle: the read would be dropped.
                pop_c = rst_n & enable & ~fifo_empty & ~fifo_wr_active;
                if (pop_c) begin
                    load_c    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                tx_valid = 1'b1;
                tx_bit   = ser_bit;
                tx_sof   = first_bit_c;
                tx_eof   = last_bit_c;
                if (tx_ready) begin
                    shift_c   = 1'b1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (last_bit_c) begin
                        bit_cnt_d    = '0;
                        word_count_d = word_count_q + CNT_W'(1);
                        if (GAP_CYCLES == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = GAP_W'(GAP_LOAD);
                        end
                    end
                end
            end

            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_rd_en = pop_c;
    assign busy       = (state_q != IDLE);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench: two serializers (MSB-first/gap 2/16-bit count and
// LSB-first/gap 0/2-bit count) share stimulus, each with its own FIFO model.
module tb_fifo_word_serializer;

    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 16;
    localparam int unsigned GAP0 = 2;
    localparam int unsigned GAP1 = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic wr_active = 1'b0;
    logic tx_ready = 1'b0;
    logic [DW-1:0] push_data = '0;

    logic          fifo_empty [2];
    logic [DW-1:0] fifo_data  [2];
    logic          rd_en      [2];
    logic          tx_valid   [2];
    logic          tx_bit     [2];
    logic          tx_sof     [2];
    logic          tx_eof     [2];
    logic          busy       [2];
    logic [CW-1:0] word_count [2];
    logic [1:0]    wc1_raw;

    assign word_count[1] = {14'b0, wc1_raw};

    always #5 clk = ~clk;

    fifo_word_serializer #(.DATA_W(DW), .MSB_FIRST(1), .GAP_CYCLES(GAP0), .CNT_W(CW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty[0]),
        .fifo_data(fifo_data[0]), .fifo_wr_active(wr_active), .fifo_rd_en(rd_en[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready), .tx_bit(tx_bit[0]), .tx_sof(tx_sof[0]),
        .tx_eof(tx_eof[0]), .busy(busy[0]), .word_count(word_count[0]));

    fifo_word_serializer #(.DATA_W(DW), .MSB_FIRST(0), .GAP_CYCLES(GAP1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty[1]),
        .fifo_data(fifo_data[1]), .fifo_wr_active(wr_active), .fifo_rd_en(rd_en[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready), .tx_bit(tx_bit[1]), .tx_sof(tx_sof[1]),
        .tx_eof(tx_eof[1]), .busy(busy[1]), .word_count(wc1_raw));

    // Reference state
    logic [DW-1:0] fq    [2][$];
    logic [2:0]    exp_q [2][$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int words_done   [2];
    int bits_in_word [2];
    int pop_cnt      [2];
    int last_pop_cyc [2];
    int last_sof_cyc [2];
    int last_eof_cyc [2];
    int gap_seen     [2];

    function automatic int unsigned gap_of(input int d);
        return (d == 0) ? GAP0 : GAP1;
    endfunction

    function automatic logic [31:0] wc_mod(input int d, input int n);
        return (d == 0) ? 32'(n % 65536) : 32'(n % 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected bit stream of one word: {bit, sof, eof} in transmit order.
    task automatic push_exp(input int d, input logic [DW-1:0] w);
        for (int i = 0; i < int'(DW); i++) begin
            int idx;
            idx = (d == 0) ? int'(DW) - 1 - i : i;
            exp_q[d].push_back({w[idx], i == 0, i == int'(DW) - 1});
        end
    endtask

    // Advance one cycle with the currently driven inputs; FIFO model commits at the edge.
    task automatic tick();
        logic pop [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) pop[d] = rd_en[d];
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (pop[d] && !wr_active && fq[d].size() > 0) push_exp(d, fq[d].pop_front());
            if (wr_active) fq[d].push_back(push_data);
            fifo_empty[d] = (fq[d].size() == 0);
            fifo_data[d]  = fifo_empty[d] ? '0 : fq[d][0];
        end
        wr_active = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        push_data = w;
        wr_active = 1'b1;
        tick();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Monitor: scoreboard pops, stall hold, pop gating, cycle-exact word count.
    initial begin : monitor
        logic       prev_stall [2];
        logic [2:0] prev_out   [2];
        for (int d = 0; d < 2; d++) begin
            prev_stall[d] = 1'b0;
            prev_out[d]   = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    prev_stall[d] = 1'b0;
                    continue;
                end
                check($sformatf("word_count%0d", d), word_count[d], wc_mod(d, words_done[d]));
                check($sformatf("rd_en_rule%0d", d), rd_en[d],
                      !busy[d] && enable && !fifo_empty[d] && !wr_active);
                if (prev_stall[d])
                    check($sformatf("stall_hold%0d", d), {tx_valid[d], tx_bit[d], tx_sof[d], tx_eof[d]},
                          {1'b1, prev_out[d]});
                if (rd_en[d]) begin
                    pop_cnt[d]++;
                    last_pop_cyc[d] = cyc;
                    gap_seen[d]     = cyc - last_eof_cyc[d];
                end
                if (tx_valid[d] && tx_ready) begin
                    if (exp_q[d].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_bit%0d: got bit %0b with no word outstanding", d, tx_bit[d]);
                    end else begin
                        check($sformatf("bit_sof_eof%0d", d), {tx_bit[d], tx_sof[d], tx_eof[d]},
                              exp_q[d].pop_front());
                    end
                    if (tx_sof[d]) last_sof_cyc[d] = cyc;
                    bits_in_word[d]++;
                    if (tx_eof[d]) begin
                        words_done[d]++;
                        bits_in_word[d] = 0;
                        last_eof_cyc[d] = cyc;
                    end
                end
                prev_stall[d] = tx_valid[d] && !tx_ready;
                prev_out[d]   = {tx_bit[d], tx_sof[d], tx_eof[d]};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base;
        int n;
        for (int d = 0; d < 2; d++) begin
            fifo_empty[d] = 1'b1;
            fifo_data[d]  = '0;
            words_done[d] = 0;
            bits_in_word[d] = 0;
            pop_cnt[d] = 0;
            last_pop_cyc[d] = 0;
            last_sof_cyc[d] = 0;
            last_eof_cyc[d] = 0;
            gap_seen[d] = 0;
        end

        // Reset state
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_tx_valid%0d", d), tx_valid[d], 0);
            check($sformatf("rst_outs%0d", d), {rd_en[d], tx_bit[d], tx_sof[d], tx_eof[d], busy[d]}, 0);
            check($sformatf("rst_word_count%0d", d), word_count[d], 0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single word 0xA5C3, ready high
        tx_ready = 1'b1;
        push_word(16'hA5C3);
        enable = 1'b1;
        run(30);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("t1_pops%0d", d), pop_cnt[d], 1);
            check($sformatf("t1_count%0d", d), word_count[d], 1);
            check($sformatf("t1_latency%0d", d), last_sof_cyc[d] - last_pop_cyc[d], 1);
            check($sformatf("t1_span%0d", d), last_eof_cyc[d] - last_sof_cyc[d], DW - 1);
            check($sformatf("t1_drained%0d", d), exp_q[d].size(), 0);
        end

        // Back-to-back: pop follows last bit after exactly the gap
        push_word(DW'($urandom));
        push_word(DW'($urandom));
        run(60);
        for (int d = 0; d < 2; d++)
            check($sformatf("b2b_gap%0d", d), gap_seen[d], 1 + gap_of(d));

        // Stalls with tx_ready pattern 1,0,0,1
        push_word(DW'($urandom));
        for (int k = 0; k < 80; k++) begin
            tx_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        tx_ready = 1'b1;
        run(10);
        for (int d = 0; d < 2; d++)
            check($sformatf("stall_drained%0d", d), exp_q[d].size() + fq[d].size(), 0);

        // Writer active 3 cycles with data waiting: no pop until the 4th cycle
        enable = 1'b0;
        push_word(DW'($urandom));
        run(1);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_data = DW'($urandom);
            wr_active = 1'b1;
            #1;
            for (int d = 0; d < 2; d++) check($sformatf("wr_block%0d_%0d", d, k), rd_en[d], 0);
            tick();
        end
        #1;
        for (int d = 0; d < 2; d++) check($sformatf("wr_release%0d", d), rd_en[d], 1);
        run(100);
        for (int d = 0; d < 2; d++)
            check($sformatf("wr_drained%0d", d), exp_q[d].size() + fq[d].size(), 0);

        // Enable dropped mid word 2 of 3
        base = pop_cnt[0];
        push_word(DW'($urandom));
        push_word(DW'($urandom));
        push_word(DW'($urandom));
        n = 0;
        while (!(pop_cnt[0] >= base + 2 && bits_in_word[0] >= 4) && n < 200) begin
            tick();
            n++;
        end
        check("en_wait_timeout", n < 200, 1);
        enable = 1'b0;
        base = words_done[0];
        run(60);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("en_left%0d", d), fq[d].size(), 1);
            check($sformatf("en_busy%0d", d), busy[d], 0);
        end
        check("en_count0", word_count[0], wc_mod(0, base + 1));
        enable = 1'b1;
        run(40);
        check("en_count_after0", word_count[0], wc_mod(0, base + 2));
        for (int d = 0; d < 2; d++) check($sformatf("en_fifo_empty%0d", d), fq[d].size(), 0);

        // Reset at bit 7 of a word
        push_word(DW'($urandom));
        push_word(DW'($urandom));
        n = 0;
        while (bits_in_word[0] != 7 && n < 200) begin
            tick();
            n++;
        end
        check("rst_wait_timeout", n < 200, 1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("mid_rst_valid%0d", d), tx_valid[d], 0);
            check($sformatf("mid_rst_busy%0d", d), busy[d], 0);
            check($sformatf("mid_rst_count%0d", d), word_count[d], 0);
            exp_q[d].delete();
            words_done[d] = 0;
            bits_in_word[d] = 0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        run(60);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("post_rst_count%0d", d), word_count[d], 1);
            check($sformatf("post_rst_drained%0d", d), exp_q[d].size() + fq[d].size(), 0);
        end

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            enable   = ($urandom % 8) != 0;
            tx_ready = ($urandom % 4) != 0;
            if (($urandom % 5) == 0 && fq[0].size() < 8) push_word(DW'($urandom));
            else tick();
        end
        enable   = 1'b1;
        tx_ready = 1'b1;
        n = 0;
        while ((fq[0].size() + fq[1].size() + exp_q[0].size() + exp_q[1].size() != 0
                || busy[0] || busy[1]) && n < 800) begin
            tick();
            n++;
        end
        check("rand_drain_timeout", n < 800, 1);
        run(4);
        for (int d = 0; d < 2; d++) check($sformatf("rand_final_count%0d", d), word_count[d], wc_mod(d, words_done[d]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
